// File: rtl/cosh_pkg.sv
// Shared definitions for the cosh Taylor-series sequencer: state encoding,
// multiplier operand selects and term-count sizing.
package cosh_pkg;

  localparam int MAX_TERMS = 8;
  localparam int CNT_W     = $clog2(MAX_TERMS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REL = 3'd1,
    INIT     = 3'd2,
    SQR      = 3'd3,
    ADD      = 3'd4,
    MULX     = 3'd5,
    MULC     = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [1:0] SEL_XX  = 2'd0;  // x * x
  localparam logic [1:0] SEL_TX2 = 2'd1;  // term * x2
  localparam logic [1:0] SEL_TC  = 2'd2;  // term * coef[count]

  function automatic logic is_busy(state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/cosh_seq_ctrl_if.sv
// Control/status bundle between the cosh sequencer and its datapath.
// master = sequencer side, slave = datapath/multiplier side.
interface cosh_seq_ctrl_if;
  logic       start;
  logic       x_zero;
  logic       mul_ack;
  logic       mul_req;
  logic [1:0] mul_sel;
  logic       ld_x;
  logic       ld_x2;
  logic       init_term;
  logic       ld_term;
  logic       clr_acc;
  logic       acc_en;
  logic [2:0] count;
  logic       co;
  logic [2:0] ps;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, x_zero, mul_ack,
    output mul_req, mul_sel, ld_x, ld_x2, init_term, ld_term, clr_acc, acc_en,
    output count, co, ps, busy, done, err
  );

  modport slave (
    output start, x_zero, mul_ack,
    input  mul_req, mul_sel, ld_x, ld_x2, init_term, ld_term, clr_acc, acc_en,
    input  count, co, ps, busy, done, err
  );
endinterface

// File: rtl/cosh_term_counter.sv
// Term index counter (ROM address) with clear, increment, jump-to-last and
// a combinational carry-out flag for the final term.
module cosh_term_counter
  import cosh_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ld_max,
  output logic [CNT_W-1:0] count,
  output logic             co
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  logic [CNT_W-1:0] count_r;

  // term index register; saturates at the last term
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (ld_max) begin
      count_r <= LAST;
    end else if (en && (count_r != LAST)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign co    = (count_r == LAST);

endmodule

// File: rtl/cosh_seq_ctrl.sv
// Sequencer for a Taylor-series cosh datapath sharing one multiplier.
// Optional multiplier-ack watchdog enabled by defining COSH_CTRL_TIMEOUT_EN.
module cosh_seq_ctrl
  import cosh_pkg::*;
#(
  parameter int N_TERMS   = 8,
  parameter int TO_CYCLES = 15
) (
  input logic             clk,
  input logic             rst,
  cosh_seq_ctrl_if.master bus
);

  state_t           state_r;
  state_t           next_fsm_s;
  state_t           next_s;
  logic             req_s;
  logic [1:0]       sel_s;
  logic             ld_x_s, ld_x2_s, init_term_s, ld_term_s, clr_acc_s, acc_en_s;
  logic             cnt_clr_s, cnt_en_s, cnt_max_s;
  logic             abort_s;
  logic [CNT_W-1:0] count_s;
  logic             co_s;

  cosh_term_counter #(.N_TERMS(N_TERMS)) u_term_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .ld_max (cnt_max_s),
    .count  (count_s),
    .co     (co_s)
  );

  // present-state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // next-state and strobe decode; multiply strobes fire on the ack cycle
  always_comb begin
    next_fsm_s  = state_r;
    req_s       = 1'b0;
    sel_s       = SEL_XX;
    ld_x_s      = 1'b0;
    ld_x2_s     = 1'b0;
    init_term_s = 1'b0;
    ld_term_s   = 1'b0;
    clr_acc_s   = 1'b0;
    acc_en_s    = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;
    cnt_max_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) next_fsm_s = WAIT_REL;
        else           next_fsm_s = state_r;
      end
      WAIT_REL: begin
        if (!bus.start) next_fsm_s = INIT;
        else            next_fsm_s = WAIT_REL;
      end
      INIT: begin
        ld_x_s      = 1'b1;
        init_term_s = 1'b1;
        clr_acc_s   = 1'b1;
        cnt_clr_s   = 1'b1;
        next_fsm_s  = SQR;
      end
      SQR: begin
        if (bus.x_zero) begin
          // every higher term is zero: only term 0 (=1) gets accumulated
          cnt_max_s  = 1'b1;
          next_fsm_s = ADD;
        end else begin
          req_s = 1'b1;
          sel_s = SEL_XX;
          if (bus.mul_ack) begin
            ld_x2_s    = 1'b1;
            next_fsm_s = ADD;
          end else begin
            next_fsm_s = SQR;
          end
        end
      end
      ADD: begin
        acc_en_s = 1'b1;
        if (co_s) next_fsm_s = DONE;
        else      next_fsm_s = MULX;
      end
      MULX: begin
        req_s = 1'b1;
        sel_s = SEL_TX2;
        if (bus.mul_ack) begin
          ld_term_s  = 1'b1;
          next_fsm_s = MULC;
        end else begin
          next_fsm_s = MULX;
        end
      end
      MULC: begin
        req_s = 1'b1;
        sel_s = SEL_TC;
        if (bus.mul_ack) begin
          ld_term_s  = 1'b1;
          cnt_en_s   = 1'b1;
          next_fsm_s = ADD;
        end else begin
          next_fsm_s = MULC;
        end
      end
      default: begin
        next_fsm_s = IDLE;
      end
    endcase
  end

  assign next_s = abort_s ? DONE : next_fsm_s;

`ifdef COSH_CTRL_TIMEOUT_EN
  localparam int             WD_W    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYCLES - 1);

  logic [WD_W-1:0] wd_r;
  logic            err_r;

  assign abort_s = req_s && !bus.mul_ack && (wd_r == WD_LAST);

  // cycles spent waiting on the current multiply request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= {WD_W{1'b0}};
    end else if (req_s && !bus.mul_ack && !abort_s) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= {WD_W{1'b0}};
    end
  end

  // sticky timeout flag, dropped as the next run enters INIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (next_s == INIT) begin
      err_r <= 1'b0;
    end else if (abort_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`else
  assign abort_s = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.mul_req   = req_s;
  assign bus.mul_sel   = sel_s;
  assign bus.ld_x      = ld_x_s;
  assign bus.ld_x2     = ld_x2_s;
  assign bus.init_term = init_term_s;
  assign bus.ld_term   = ld_term_s;
  assign bus.clr_acc   = clr_acc_s;
  assign bus.acc_en    = acc_en_s;
  assign bus.count     = count_s;
  assign bus.co        = co_s;
  assign bus.ps        = state_r;
  assign bus.busy      = is_busy(state_r);
  assign bus.done      = (state_r == DONE);

endmodule

// File: tb/tb_cosh_seq_ctrl.sv
// Directed bench for cosh_seq_ctrl: per-run expected traces built from the
// sequencing rules, replayed cycle by cycle against the DUT outputs.
module tb_cosh_seq_ctrl;

  localparam int NT   = 8;
  localparam int LAST = NT - 1;
  localparam int TO   = 15;

  localparam logic [5:0] S_LDX  = 6'b100000;
  localparam logic [5:0] S_LDX2 = 6'b010000;
  localparam logic [5:0] S_INIT = 6'b001000;
  localparam logic [5:0] S_LDT  = 6'b000100;
  localparam logic [5:0] S_CLR  = 6'b000010;
  localparam logic [5:0] S_ACC  = 6'b000001;

  typedef struct packed {
    logic       start;
    logic       xz;
    logic       ack;
    logic [2:0] ps;
    logic       req;
    logic [1:0] sel;
    logic [5:0] strb;
    logic [2:0] cnt;
    logic       co;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec;
  int   n_err;
  int   m_cnt;
  bit   m_done;
  bit   m_err;
  vec_t q[$];

  always #5 clk = ~clk;

  cosh_seq_ctrl_if bus ();

  cosh_seq_ctrl #(.N_TERMS(NT), .TO_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [18:0] exp_out(vec_t v);
    return {v.ps, v.req, v.sel, v.strb, v.cnt, v.co, v.busy, v.done, v.err};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.ps, bus.mul_req, bus.mul_sel, bus.ld_x, bus.ld_x2, bus.init_term,
            bus.ld_term, bus.clr_acc, bus.acc_en, bus.count, bus.co, bus.busy,
            bus.done, bus.err};
  endfunction

  function automatic void add(bit st, bit xz, bit ack, int ps, bit req, int sel,
                              logic [5:0] strb);
    vec_t v;
    v.start = st;
    v.xz    = xz;
    v.ack   = ack;
    v.ps    = 3'(ps);
    v.req   = req;
    v.sel   = 2'(sel);
    v.strb  = strb;
    v.cnt   = 3'(m_cnt);
    v.co    = (m_cnt == LAST);
    v.busy  = (ps >= 1) && (ps <= 6);
    v.done  = (ps == 7);
    v.err   = m_err;
    q.push_back(v);
  endfunction

  // one multiply: d wait cycles, then the ack cycle carrying the strobe
  function automatic void mul(int ps, int sel, logic [5:0] strb, int d, bit st);
    for (int j = 0; j <= d; j++)
      add(st, 1'b0, (j == d), ps, 1'b1, sel, (j == d) ? strb : 6'b000000);
  endfunction

  // whole run: start held `hold` cycles, ack latency d, background ack bg,
  // start re-pulsed during MULX of term start_k, hang = no ack in first MULX
  function automatic void build(int hold, int d, bit xz, bit bg, int start_k, bit hang);
    add(1'b1, xz, bg, m_done ? 7 : 0, 1'b0, 0, 6'b000000);
    for (int i = 1; i < hold; i++) add(1'b1, xz, bg, 1, 1'b0, 0, 6'b000000);
    add(1'b0, xz, bg, 1, 1'b0, 0, 6'b000000);
    m_err = 1'b0;
    add(1'b0, xz, bg, 2, 1'b0, 0, S_LDX | S_INIT | S_CLR);
    m_cnt = 0;
    if (xz) begin
      add(1'b0, 1'b1, bg, 3, 1'b0, 0, 6'b000000);
      m_cnt = LAST;
    end else begin
      mul(3, 0, S_LDX2, d, 1'b0);
    end
    for (int k = 0; k < NT; k++) begin
      add(1'b0, xz, bg, 4, 1'b0, 0, S_ACC);
      if (m_cnt == LAST) break;
      if (hang) begin
        for (int j = 0; j < TO; j++) add(1'b0, 1'b0, 1'b0, 5, 1'b1, 1, 6'b000000);
        m_err = 1'b1;
        break;
      end
      mul(5, 1, S_LDT, d, (k == start_k));
      mul(6, 2, S_LDT, d, 1'b0);
      m_cnt++;
    end
    m_done = 1'b1;
    add(1'b0, xz, bg, 7, 1'b0, 0, 6'b000000);
  endfunction

  // edges from start-release sampling to the first DONE cycle in the model
  function automatic int model_lat();
    int r = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].ps == 3'd1 && !q[i].start && r < 0) r = i;
      if (q[i].ps == 3'd7 && r >= 0) return i - r - 1;
    end
    return -1;
  endfunction

  function automatic int count_field(bit want_req);
    int n = 0;
    for (int i = 0; i < q.size(); i++)
      if (want_req ? q[i].req : q[i].strb[0]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic play(input string tag, output int lat);
    int rel = -1;
    int dn  = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      bus.start   = q[i].start;
      bus.x_zero  = q[i].xz;
      bus.mul_ack = q[i].ack;
      @(negedge clk);
      n_vec++;
      if (dut_out() !== exp_out(q[i])) begin
        n_err++;
        $display("FAIL %s cyc %0d: got %b want %b (ps cnt co busy done err order)",
                 tag, i, dut_out(), exp_out(q[i]));
      end
      if (q[i].ps == 3'd1 && !q[i].start && rel < 0) rel = i;
      if (bus.done === 1'b1 && rel >= 0 && dn < 0) dn = i;
    end
    lat = (dn < 0) ? -1 : dn - rel - 1;
    q.delete();
  endtask

  initial begin
    int lat;
    n_vec       = 0;
    n_err       = 0;
    m_cnt       = 0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.x_zero  = 1'b0;
    bus.mul_ack = 1'b0;

    @(negedge clk);
    check("reset_outputs", int'(dut_out()), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // start held 3 cycles, ack tied high
    build(3, 0, 1'b0, 1'b1, -1, 1'b0);
    check("model_lat_seq", model_lat(), 24);
    play("seq", lat);
    check("dut_lat_seq", lat, 24);

    // x == 0: no multiplies, single accumulate, from DONE
    build(1, 0, 1'b1, 1'b0, -1, 1'b0);
    check("model_lat_xzero", model_lat(), 3);
    check("model_req_xzero", count_field(1'b1), 0);
    check("model_acc_xzero", count_field(1'b0), 1);
    play("xzero", lat);
    check("dut_lat_xzero", lat, 3);

    // ack after 4 wait cycles in every multiply state
    build(2, 4, 1'b0, 1'b0, -1, 1'b0);
    check("model_lat_delay4", model_lat(), 84);
    play("delay4", lat);
    check("dut_lat_delay4", lat, 84);

    // start re-pulsed in MULX, stray acks outside multiply states
    build(1, 1, 1'b0, 1'b1, 2, 1'b0);
    check("model_lat_stray", model_lat(), 39);
    play("stray", lat);
    check("dut_lat_stray", lat, 39);

    // asynchronous reset mid-MULC, before its ack
    build(1, 4, 1'b0, 1'b0, -1, 1'b0);
    while (q.size() > 0 && q[$].ps != 3'd6) void'(q.pop_back());
    void'(q.pop_back());
    play("pre_rst", lat);
    #2;
    rst         = 1'b1;
    bus.mul_ack = 1'b0;
    bus.start   = 1'b0;
    #1;
    check("async_rst_outputs", int'(dut_out()), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_err  = 1'b0;

    build(1, 0, 1'b0, 1'b0, -1, 1'b0);
    play("post_rst", lat);
    check("dut_lat_post_rst", lat, 24);

`ifdef COSH_CTRL_TIMEOUT_EN
    build(1, 0, 1'b0, 1'b0, -1, 1'b1);
    play("timeout", lat);
    build(1, 0, 1'b0, 1'b0, -1, 1'b0);
    play("restart", lat);
    check("dut_lat_restart", lat, 24);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cosh_seq_ctrl.md
COSH_SEQ_CTRL -- requirements
Module: cosh_seq_ctrl

Interface
REQ-001 SHALL provide parameter N_TERMS, default 8, meaning Taylor terms summed (k = 0..N_TERMS-1, legal 2..8).
REQ-002 SHALL provide parameter TO_CYCLES, default 15, meaning the multiplier-ack watchdog limit in cycles (used only with COSH_CTRL_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all flops rise-edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, meaning the run request; may be held high for many cycles.
REQ-006 SHALL have port x_zero, input, 1, meaning the datapath x register equals 0 (zero check).
REQ-007 SHALL have port mul_ack, input, 1, meaning a one-cycle pulse from the shared multiplier: product valid.
REQ-008 SHALL have port mul_req, output, 1, meaning the multiply request, held until ack.
REQ-009 SHALL have port mul_sel, output, 2, meaning the operand select: 0 = x*x, 1 = term*x2, 2 = term*coef[count].
REQ-010 SHALL have ports ld_x, ld_x2, init_term, ld_term, clr_acc and acc_en, each output, 1, meaning the datapath register strobes.
REQ-011 SHALL have port count, output, 3, meaning the current term index (ROM address).
REQ-012 SHALL have port co, output, 1, meaning count == N_TERMS-1.
REQ-013 SHALL have port ps, output, 3, meaning the present-state encoding.
REQ-014 SHALL have ports busy, done and err, each output, 1, meaning status.

Function
REQ-015 SHALL implement these states and ps codes: IDLE=0, WAIT_REL=1, INIT=2, SQR=3, ADD=4, MULX=5, MULC=6, DONE=7.
REQ-016 In IDLE and DONE, start=1 SHALL cause a transition to WAIT_REL; WAIT_REL SHALL remain until start=0, then go to INIT (start-release handshake).
REQ-017 INIT SHALL pulse ld_x, init_term (term=1) and clr_acc for one cycle, clear count to 0, then go to SQR.
REQ-018 In SQR, if x_zero=1, the block SHALL skip the multiply, force count=N_TERMS-1 and go to ADD; otherwise it SHALL assert mul_req with mul_sel=0, and on mul_ack pulse ld_x2 and go to ADD.
REQ-019 ADD SHALL pulse acc_en for one cycle; if co=1 it SHALL go to DONE, else to MULX.
REQ-020 MULX SHALL assert mul_req with mul_sel=1; on mul_ack it SHALL pulse ld_term and go to MULC.
REQ-021 MULC SHALL assert mul_req with mul_sel=2; on mul_ack it SHALL pulse ld_term, increment count and go to ADD.
REQ-022 mul_req SHALL stay high every cycle of SQR/MULX/MULC until mul_ack is sampled; an ack in the first cycle SHALL give a one-cycle state; mul_ack outside these states SHALL be ignored.
REQ-023 busy SHALL be 1 in states 1..6; start while in states 2..6 SHALL be ignored.
REQ-024 done SHALL be 1 throughout DONE and SHALL clear on the cycle DONE exits to WAIT_REL.
REQ-025 With zero-wait ack and N_TERMS=8, done SHALL rise 24 edges after the edge at which WAIT_REL samples start=0; with x_zero=1 it SHALL rise 3 edges after.
REQ-026 count SHALL never exceed N_TERMS-1, and co SHALL be combinational from count.

Reset
REQ-027 rst=1 SHALL force IDLE asynchronously at any time, including mid-multiply; count=0 and every output SHALL be 0.

Configuration
REQ-028 With COSH_CTRL_TIMEOUT_EN defined, a per-request cycle counter SHALL abort to DONE with err=1 when TO_CYCLES cycles elapse without mul_ack; err SHALL clear on the next INIT.
REQ-029 Without COSH_CTRL_TIMEOUT_EN, the block SHALL wait indefinitely for mul_ack and err SHALL be tied 0.

Structure
REQ-030 A shared package cosh_pkg SHALL hold the state enum (3-bit), the mul_sel encodings and the constant MAX_TERMS=8.
REQ-031 The term counter (clear, enable, co) SHALL be a sub-module cosh_term_counter; the FSM and watchdog SHALL live in cosh_seq_ctrl.

Verification
REQ-032 Scenario: rst pulse mid-MULC -> ps=0, mul_req=0, count=0 and done=0 asynchronously.
REQ-033 Scenario: start high for 3 cycles, then low, ack always 1 -> ps sequence 1,2,3,4,5,6,4,..., done at edge 24, and count reaches 7 with co=1.
REQ-034 Scenario: x_zero=1 -> no mul_req at all, a single acc_en, done after 3 edges.
REQ-035 Scenario: mul_ack delayed 4 cycles in each multiply state -> mul_req held steady, each of SQR/MULX/MULC occupies 5 cycles, result order unchanged.
REQ-036 Scenario: start pulsed during MULX; a stray mul_ack in ADD -> both ignored, sequence identical to REQ-033.
REQ-037 Scenario, with COSH_CTRL_TIMEOUT_EN: mul_ack never arrives in MULX -> after 15 cycles ps=7, err=1 and done=1; restarting clears err at INIT.
